// File: rtl/il_pkg.sv
// Shared constants for the task-clock interruption controller: default sizes,
// FSM state encoding and reset values.
package il_pkg;

  localparam int unsigned CNT_W_DEF  = 48;
  localparam int unsigned NUM_BP_DEF = 4;
  localparam int unsigned STEP_W_DEF = 16;

  localparam logic [1:0] ST_HALT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_BREAK = 2'd3;

  localparam logic [1:0] RST_STATE = ST_HALT;

  // Halt cause sits just above the per-breakpoint cause bits.
  function automatic int unsigned cause_halt(input int unsigned num_bp);
    return num_bp;
  endfunction

endpackage

// File: rtl/il_bp_cmp.sv
// Parallel breakpoint comparators: one enable-masked equality compare per
// breakpoint against the registered task-cycle count.
module il_bp_cmp
  import il_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned NUM_BP = NUM_BP_DEF
) (
  input  logic [NUM_BP-1:0]       bp_enable,
  input  logic [NUM_BP*CNT_W-1:0] bp_value,
  input  logic [CNT_W-1:0]        cycle_count,
  output logic [NUM_BP-1:0]       hit_vec
);

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit_vec[i] = bp_enable[i] && (bp_value[i*CNT_W +: CNT_W] == cycle_count);
    end
  end

endmodule

// File: rtl/interruption_logic_mc.sv
// Task-clock interruption controller: gates sys_clk so an exact number of task
// edges is delivered (breakpoints, N-step, halt, resume). IL_BUFGCE_EN selects a
// real BUFGCE gate; otherwise task_clk is sys_clk and task_clk_en is the enable.
module interruption_logic_mc
  import il_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned NUM_BP = NUM_BP_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic                    sys_clk,
  input  logic                    sys_reset_n,
  input  logic                    run_req,
  input  logic                    halt_req,
  input  logic                    step_req,
  input  logic [STEP_W-1:0]       step_count,
  input  logic                    cnt_clr,
  input  logic [NUM_BP-1:0]       bp_enable,
  input  logic [NUM_BP*CNT_W-1:0] bp_value,
  output logic                    task_clk,
  output logic                    task_clk_en,
  output logic                    break_active,
  output logic [NUM_BP:0]         break_cause,
  output logic [CNT_W-1:0]        cycle_count,
  output logic                    cnt_wrap,
  output logic [1:0]              state
);

  localparam int unsigned CAUSE_W    = NUM_BP + 1;
  localparam int unsigned CAUSE_HALT = cause_halt(NUM_BP);

  logic [NUM_BP-1:0]  hit_vec;
  logic               hit;
  logic               skip_once, skip_d;
  logic [STEP_W-1:0]  step_left, step_left_d, step_load;
  logic [1:0]         state_d;
  logic [CAUSE_W-1:0] cause_d, halt_cause;
  logic [CNT_W-1:0]   count_d;
  logic               wrap_d, break_d;

  il_bp_cmp #(.CNT_W(CNT_W), .NUM_BP(NUM_BP)) u_bp_cmp (
    .bp_enable   (bp_enable),
    .bp_value    (bp_value),
    .cycle_count (cycle_count),
    .hit_vec     (hit_vec)
  );

  assign hit         = (|hit_vec) & ~skip_once;
  assign task_clk_en = ((state == ST_RUN) || (state == ST_STEP)) & ~hit & ~halt_req;
  assign step_load   = (step_count == '0) ? STEP_W'(1) : step_count;
  assign halt_cause  = CAUSE_W'(1) << CAUSE_HALT;

`ifdef IL_BUFGCE_EN
  BUFGCE u_task_bufgce (.I(sys_clk), .CE(task_clk_en), .O(task_clk));
`else
  assign task_clk = sys_clk;
`endif

  // Next-state, counter and status update
  always_comb begin
    state_d     = state;
    step_left_d = step_left;
    skip_d      = skip_once;
    cause_d     = break_cause;
    count_d     = cycle_count;
    wrap_d      = cnt_wrap;

    if (task_clk_en) begin
      count_d = cycle_count + CNT_W'(1);
      if (count_d == '0) wrap_d = 1'b1;
      skip_d = 1'b0;
    end else if (cnt_clr) begin
      count_d = '0;
      wrap_d  = 1'b0;
    end

    case (state)
      ST_HALT: begin
        if (!halt_req) begin
          if (step_req) begin
            state_d     = ST_STEP;
            step_left_d = step_load;
          end else if (run_req) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
          cause_d = halt_cause;
        end else if (hit) begin
          state_d = ST_BREAK;
          cause_d = {1'b0, hit_vec};
        end else if (step_req) begin
          state_d     = ST_STEP;
          step_left_d = step_load;
        end
      end
      ST_STEP: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (hit) begin
          state_d = ST_BREAK;
          cause_d = {1'b0, hit_vec};
        end else begin
          // Without halt or hit the enable is high, so this is an edge cycle.
          step_left_d = step_left - STEP_W'(1);
          if (step_left == STEP_W'(1)) state_d = ST_HALT;
        end
      end
      ST_BREAK: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (step_req) begin
          state_d     = ST_STEP;
          step_left_d = step_load;
          skip_d      = 1'b1;
        end else if (run_req) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end
      end
      default: state_d = ST_HALT;
    endcase

    break_d = (state_d == ST_BREAK);
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state        <= RST_STATE;
      step_left    <= '0;
      skip_once    <= 1'b0;
      break_cause  <= '0;
      break_active <= 1'b0;
      cycle_count  <= '0;
      cnt_wrap     <= 1'b0;
    end else begin
      state        <= state_d;
      step_left    <= step_left_d;
      skip_once    <= skip_d;
      break_cause  <= cause_d;
      break_active <= break_d;
      cycle_count  <= count_d;
      cnt_wrap     <= wrap_d;
    end
  end

endmodule

// File: tb/tb_interruption_logic_mc.sv
// Self-checking bench for interruption_logic_mc: directed scenarios plus
// randomized run/step sequences against a distance-to-breakpoint model.
module tb_interruption_logic_mc;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NUM_BP = 4;
  localparam int unsigned STEP_W = 16;
  localparam int          MODV   = 1 << CNT_W;
  localparam int          BUDGET = 700;

  logic                    sys_clk     = 1'b0;
  logic                    sys_reset_n = 1'b0;
  logic                    run_req     = 1'b0;
  logic                    halt_req    = 1'b0;
  logic                    step_req    = 1'b0;
  logic                    cnt_clr     = 1'b0;
  logic [STEP_W-1:0]       step_count  = '0;
  logic [NUM_BP-1:0]       bp_enable   = '0;
  logic [NUM_BP*CNT_W-1:0] bp_value    = '0;
  logic                    task_clk, task_clk_en, break_active, cnt_wrap;
  logic [NUM_BP:0]         break_cause;
  logic [CNT_W-1:0]        cycle_count;
  logic [1:0]              state;

  int vectors = 0;
  int errors  = 0;

  // Reference model: edges delivered, sticky wrap, skip-after-resume, last cause
  int              m_count;
  bit              m_wrap;
  bit              m_skip;
  int              m_state;
  logic [NUM_BP:0] m_cause;

  interruption_logic_mc #(.CNT_W(CNT_W), .NUM_BP(NUM_BP), .STEP_W(STEP_W)) dut (
    .sys_clk      (sys_clk),
    .sys_reset_n  (sys_reset_n),
    .run_req      (run_req),
    .halt_req     (halt_req),
    .step_req     (step_req),
    .step_count   (step_count),
    .cnt_clr      (cnt_clr),
    .bp_enable    (bp_enable),
    .bp_value     (bp_value),
    .task_clk     (task_clk),
    .task_clk_en  (task_clk_en),
    .break_active (break_active),
    .break_cause  (break_cause),
    .cycle_count  (cycle_count),
    .cnt_wrap     (cnt_wrap),
    .state        (state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic pulse(input int kind);
    @(posedge sys_clk); #1;
    case (kind)
      0: run_req  = 1'b1;
      1: step_req = 1'b1;
      2: halt_req = 1'b1;
      default: cnt_clr = 1'b1;
    endcase
    @(posedge sys_clk); #1;
    run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; cnt_clr = 1'b0;
  endtask

  // Counts enabled cycles until the FSM leaves RUN/STEP or the budget expires.
  task automatic run_until_stop(output int edges, output bit timeout);
    edges   = 0;
    timeout = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge sys_clk);
      if (task_clk_en) edges++;
      @(posedge sys_clk); #1;
      if (state == 2'd0 || state == 2'd3) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic set_bp(input int i, input int v);
    bp_value[i*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  function automatic int bp_dist(input int i);
    int d;
    d = (int'(bp_value[i*CNT_W +: CNT_W]) - m_count + MODV) % MODV;
    if (d == 0 && m_skip) d = MODV;
    return d;
  endfunction

  // Nearest armed breakpoint decides whether the request ends in BREAK.
  task automatic predict(input int limit, output int edges, output logic [NUM_BP:0] cause,
                         output bit brk);
    int best;
    best  = 1 << 30;
    cause = '0;
    for (int i = 0; i < NUM_BP; i++)
      if (bp_enable[i] && bp_dist(i) < best) best = bp_dist(i);
    brk = (best < limit);
    if (brk) begin
      edges = best;
      for (int i = 0; i < NUM_BP; i++)
        if (bp_enable[i] && bp_dist(i) == best) cause[i] = 1'b1;
    end else begin
      edges = limit;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge sys_clk);
    #1;
    vectors++; if (task_clk_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", task_clk_en); end
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    vectors++; if (cycle_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
    vectors++; if (break_cause !== '0) begin errors++; $display("FAIL reset_cause got=%b exp=0", break_cause); end
    vectors++; if (cnt_wrap !== 1'b0 || break_active !== 1'b0) begin errors++; $display("FAIL reset_flags got wrap=%b brk=%b exp 0 0", cnt_wrap, break_active); end
    vectors++; if (task_clk !== sys_clk) begin errors++; $display("FAIL task_clk got=%b exp=%b", task_clk, sys_clk); end
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
  endtask

  task automatic test_bp_run;
    int edges; bit to;
    set_bp(0, 100); bp_enable = 4'b0001;
    pulse(0);
    run_until_stop(edges, to);
    vectors++; if (to || edges != 100) begin errors++; $display("FAIL bp_run_edges got=%0d timeout=%b exp=100", edges, to); end
    vectors++; if (state !== 2'd3 || cycle_count !== 8'd100) begin errors++; $display("FAIL bp_run_state got st=%0d cnt=%0d exp st=3 cnt=100", state, cycle_count); end
    vectors++; if (break_cause !== 5'b00001 || break_active !== 1'b1) begin errors++; $display("FAIL bp_run_cause got=%b brk=%b exp=00001 brk=1", break_cause, break_active); end
  endtask

  task automatic test_resume;
    int edges; bit to;
    set_bp(1, 105); bp_enable = 4'b0011;
    pulse(0);
    run_until_stop(edges, to);
    vectors++; if (to || edges != 5) begin errors++; $display("FAIL resume_edges got=%0d timeout=%b exp=5", edges, to); end
    vectors++; if (state !== 2'd3 || cycle_count !== 8'd105) begin errors++; $display("FAIL resume_state got st=%0d cnt=%0d exp st=3 cnt=105", state, cycle_count); end
    vectors++; if (break_cause !== 5'b00010) begin errors++; $display("FAIL resume_cause got=%b exp=00010", break_cause); end
  endtask

  task automatic test_step;
    int edges; bit to;
    pulse(2);
    vectors++; if (state !== 2'd0 || break_active !== 1'b0) begin errors++; $display("FAIL break_halt got st=%0d brk=%b exp st=0 brk=0", state, break_active); end
    bp_enable = '0;
    step_count = STEP_W'(7);
    pulse(1);
    run_until_stop(edges, to);
    vectors++; if (to || edges != 7 || state !== 2'd0 || cycle_count !== 8'd112) begin errors++; $display("FAIL step7 got edges=%0d st=%0d cnt=%0d exp 7 0 112", edges, state, cycle_count); end
    step_count = '0;
    pulse(1);
    run_until_stop(edges, to);
    vectors++; if (to || edges != 1 || state !== 2'd0 || cycle_count !== 8'd113) begin errors++; $display("FAIL step0 got edges=%0d st=%0d cnt=%0d exp 1 0 113", edges, state, cycle_count); end
  endtask

  task automatic test_halt_priority;
    pulse(0);
    repeat (3) @(posedge sys_clk);
    #1;
    halt_req = 1'b1; run_req = 1'b1;
    #1;
    vectors++; if (task_clk_en !== 1'b0) begin errors++; $display("FAIL halt_same_cycle_en got=%b exp=0", task_clk_en); end
    @(posedge sys_clk); #1;
    halt_req = 1'b0; run_req = 1'b0;
    vectors++; if (state !== 2'd0 || break_active !== 1'b0) begin errors++; $display("FAIL halt_state got st=%0d brk=%b exp st=0 brk=0", state, break_active); end
    vectors++; if (break_cause !== 5'b10000 || cycle_count !== 8'd116) begin errors++; $display("FAIL halt_cause got=%b cnt=%0d exp=10000 cnt=116", break_cause, cycle_count); end
  endtask

  task automatic test_wrap_clear;
    int edges; bit to;
    set_bp(0, 255); bp_enable = 4'b0001;
    pulse(0);
    run_until_stop(edges, to);
    vectors++; if (to || edges != 139 || cycle_count !== 8'd255) begin errors++; $display("FAIL to255 got edges=%0d cnt=%0d exp 139 255", edges, cycle_count); end
    bp_enable = '0;
    step_count = STEP_W'(1);
    pulse(1);
    run_until_stop(edges, to);
    vectors++; if (cycle_count !== 8'd0 || cnt_wrap !== 1'b1) begin errors++; $display("FAIL wrap got cnt=%0d wrap=%b exp 0 1", cycle_count, cnt_wrap); end
    step_count = STEP_W'(5);
    pulse(1);
    run_until_stop(edges, to);
    pulse(3);
    vectors++; if (cycle_count !== 8'd0 || cnt_wrap !== 1'b0) begin errors++; $display("FAIL clr_halt got cnt=%0d wrap=%b exp 0 0", cycle_count, cnt_wrap); end
    pulse(0);
    repeat (2) @(posedge sys_clk);
    #1; cnt_clr = 1'b1;
    @(posedge sys_clk); #1;
    cnt_clr = 1'b0; halt_req = 1'b1;
    @(posedge sys_clk); #1;
    halt_req = 1'b0;
    vectors++; if (cycle_count !== 8'd3 || state !== 2'd0) begin errors++; $display("FAIL clr_ignored got cnt=%0d st=%0d exp 3 0", cycle_count, state); end
  endtask

  task automatic test_zero_bp;
    int edges; bit to;
    pulse(3);
    set_bp(0, 0); bp_enable = 4'b0001;
    pulse(0);
    run_until_stop(edges, to);
    vectors++; if (to || edges != 0 || state !== 2'd3 || cycle_count !== 8'd0) begin errors++; $display("FAIL zero_bp got edges=%0d st=%0d cnt=%0d exp 0 3 0", edges, state, cycle_count); end
    vectors++; if (break_cause !== 5'b00001) begin errors++; $display("FAIL zero_bp_cause got=%b exp=00001", break_cause); end
  endtask

  task automatic test_random;
    int edges, exp_edges, limit, sc;
    bit to, brk, do_step;
    logic [NUM_BP:0] exp_cause;
    m_count = 0; m_wrap = 1'b0; m_skip = 1'b0; m_state = 3; m_cause = 5'b00001;
    for (int it = 0; it < 30; it++) begin
      do_step = ($urandom_range(0, 1) == 1);
      bp_enable = do_step ? NUM_BP'($urandom_range(0, 15)) : NUM_BP'($urandom_range(1, 15));
      for (int i = 0; i < NUM_BP; i++) set_bp(i, (m_count + int'($urandom_range(0, 60))) % MODV);
      sc = int'($urandom_range(0, 40));
      step_count = STEP_W'(sc);
      limit = do_step ? ((sc == 0) ? 1 : sc) : (1 << 30);
      if (m_state == 3) m_skip = 1'b1;
      predict(limit, exp_edges, exp_cause, brk);
      pulse(do_step ? 1 : 0);
      run_until_stop(edges, to);
      m_count = m_count + exp_edges;
      if (m_count >= MODV) begin m_wrap = 1'b1; m_count = m_count % MODV; end
      if (exp_edges > 0) m_skip = 1'b0;
      m_state = brk ? 3 : 0;
      if (brk) m_cause = exp_cause;
      vectors++;
      if (to || edges != exp_edges || int'(state) != m_state || int'(cycle_count) != m_count) begin
        errors++;
        $display("FAIL rand_%0d got edges=%0d st=%0d cnt=%0d exp edges=%0d st=%0d cnt=%0d", it, edges, state, cycle_count, exp_edges, m_state, m_count);
      end
      vectors++;
      if (break_cause !== m_cause || break_active !== brk || cnt_wrap !== m_wrap) begin
        errors++;
        $display("FAIL rand_status_%0d got cause=%b brk=%b wrap=%b exp cause=%b brk=%b wrap=%b", it, break_cause, break_active, cnt_wrap, m_cause, brk, m_wrap);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    bit found;
    found = 1'b0;
    bp_enable = '0;
    pulse(2);
    pulse(3);
    pulse(0);
    for (int c = 0; c < 100; c++) begin
      @(negedge sys_clk);
      if (cycle_count == 8'd37) begin found = 1'b1; break; end
    end
    vectors++; if (!found) begin errors++; $display("FAIL mid_run_reach37 got cnt=%0d exp=37", cycle_count); end
    #1; sys_reset_n = 1'b0;
    #1;
    vectors++; if (task_clk_en !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL mid_reset got en=%b st=%0d exp 0 0", task_clk_en, state); end
    vectors++; if (cycle_count !== '0 || break_cause !== '0 || cnt_wrap !== 1'b0) begin errors++; $display("FAIL mid_reset_regs got cnt=%0d cause=%b wrap=%b exp 0 0 0", cycle_count, break_cause, cnt_wrap); end
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bp_run();
    test_resume();
    test_step();
    test_halt_priority();
    test_wrap_clear();
    test_zero_bp();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/interruption_logic_mc.md
Name: interruption_logic_mc

Overview:
Parametrised multi-breakpoint task-clock interruption controller. It sits between sys_clk and the design under debug, and gates the task clock so an exact number of task edges is delivered. It supports NUM_BP independent cycle breakpoints, N-cycle stepping, external halt and resume-from-break. Control comes from the debug VIO/host logic; status is read back by the same host.

Parameters:
CNT_W, 48, width of task-cycle counter and breakpoint values
NUM_BP, 4, number of independent breakpoint comparators
STEP_W, 16, width of step-count request

Ports:
sys_clk  input  1  free-running system clock; only clock
sys_reset_n  input  1  asynchronous active-low reset
run_req  input  1  single-cycle pulse: start/resume free run
halt_req  input  1  single-cycle pulse: stop at next edge (external trigger)
step_req  input  1  single-cycle pulse: deliver step_count task edges
step_count  input  STEP_W  edges per step; 0 treated as 1
cnt_clr  input  1  pulse: clear cycle_count; honoured only while task_clk_en=0
bp_enable  input  NUM_BP  per-breakpoint arm
bp_value  input  NUM_BP*CNT_W  breakpoint i in bits [i*CNT_W +: CNT_W]
task_clk  output  1  gated task clock
task_clk_en  output  1  combinational clock enable driving the gate
break  output  1  high while in BREAK
break_cause  output  NUM_BP+1  bit i = bp i hit; bit NUM_BP = halt_req
cycle_count  output  CNT_W  task edges delivered since clear
cnt_wrap  output  1  sticky: cycle_count wrapped; cleared by cnt_clr
state  output  2  HALT=0, RUN=1, STEP=2, BREAK=3

Behaviour:
- Reset (async, immediate): state=HALT, task_clk_en=0, break=0, break_cause=0, cycle_count=0, cnt_wrap=0, step_left=0, skip_once=0.
- hit = OR over i of (bp_enable[i] & bp_value[i]==cycle_count) & ~skip_once. Compares use registered count only.
- task_clk_en = (state==RUN | state==STEP) & ~hit & ~halt_req. It is combinational from registers and halt_req, so halt takes effect on the same cycle.
- Each cycle with task_clk_en=1: cycle_count+1 (mod 2^CNT_W). On the 0 wrap, cnt_wrap<=1. skip_once<=0.
- Exactness: breakpoint value V stops with exactly V task edges delivered since clear; cycle_count==V in BREAK.
- Request priority in the same cycle: halt_req > step_req > run_req.
- FSM transitions:
  - HALT: step_req -> STEP, step_left<=max(step_count,1); run_req -> RUN.
  - RUN: halt_req -> HALT, break_cause<=1<<NUM_BP, break stays 0; hit -> BREAK, break_cause<=hit vector; step_req -> STEP.
  - STEP: en cycle decrements step_left; en with step_left==1 -> HALT. hit -> BREAK (breakpoints active in STEP). halt_req -> HALT.
  - BREAK: run_req -> RUN with skip_once<=1; step_req -> STEP with skip_once<=1; halt_req -> HALT. break_cause holds until next BREAK entry or reset.
- skip_once masks only the current count value: the first en cycle after resume passes, and later matches fire again.
- Two bps with equal value: both cause bits set. A disabled bp never sets its cause bit.
- cnt_clr while task_clk_en=1 is ignored. Clear to 0 with bp_value=0 armed -> next run/step breaks immediately with 0 edges.
- bp_value/bp_enable changes take effect on the next cycle's compare; no latching.

Optional Feature:
IL_BUFGCE_EN
- Defined: task_clk driven by a BUFGCE (I=sys_clk, CE=task_clk_en).
- Undefined: task_clk=sys_clk ungated. Consumers must use task_clk_en as a clock enable. Simulation-friendly, with identical counter/FSM behaviour.

Decomposition:
- Package il_pkg: state encoding constants (HALT/RUN/STEP/BREAK), cause-bit index CAUSE_HALT=NUM_BP, reset value constants.
- Sub-module il_bp_cmp: NUM_BP parallel comparators plus enable masking. Outputs hit_vec[NUM_BP]; the top applies skip_once.

Test Plan:
- Reset mid-RUN at count 37 -> task_clk_en=0 immediately, state=HALT, cycle_count=0, cause=0.
- bp0=100 armed, run_req -> exactly 100 en cycles, state=BREAK, cycle_count=100, break_cause=0b00001.
- In BREAK at 100, bp1=105, run_req -> 5 more en cycles, BREAK at 105, cause=0b00010. bp0 does not re-fire.
- From HALT, step_count=7, step_req -> 7 en cycles, HALT, count+7. Then step_count=0 -> 1 edge.
- RUN with halt_req and run_req in the same cycle -> en=0 that cycle, HALT, cause=0b10000, break=0.
- CNT_W=8, count=255, run -> wrap to 0, cnt_wrap=1. Then cnt_clr in HALT -> count=0, cnt_wrap=0.
